// File: rtl/alu_decode_stage_pkg.sv
// ============================================================================
// Module  : alu_decode_stage_pkg
// Brief   : MIPS opcode/funct constants and the decoded control bundle shared
//           by the decode stage, the ALU and the CPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_decode_stage_pkg;

  localparam logic [5:0] RTYPE_OP  = 6'h00;
  localparam logic [5:0] J_OP      = 6'h02;
  localparam logic [5:0] JAL_OP    = 6'h03;
  localparam logic [5:0] BEQ_OP    = 6'h04;
  localparam logic [5:0] BNE_OP    = 6'h05;
  localparam logic [5:0] ADDI_OP   = 6'h08;
  localparam logic [5:0] XORI_OP   = 6'h0E;
  localparam logic [5:0] LW_OP     = 6'h23;
  localparam logic [5:0] SW_OP     = 6'h2B;

  localparam logic [5:0] JR_FUNCT  = 6'h08;
  localparam logic [5:0] ADD_FUNCT = 6'h20;
  localparam logic [5:0] SUB_FUNCT = 6'h22;
  localparam logic [5:0] SLT_FUNCT = 6'h2A;

  localparam logic [4:0] LINK_REG  = 5'd31;

  typedef struct packed {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] write_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_imm;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       illegal;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/alu_decode_stage_if.sv
// ============================================================================
// Module  : alu_decode_stage_if
// Brief   : Fetch-side and execute-side handshake bundle of the decode stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_decode_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_inst;
  logic [DATA_W-1:0] in_pc;

  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_opcode;
  logic [5:0]        out_funct;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_write_reg;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_jump_target;
  logic [DATA_W-1:0] out_pc_plus4;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_alu_src_imm;
  logic              out_branch;
  logic              out_jump;
  logic              out_jump_reg;
  logic              out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt,
           out_write_reg, out_imm, out_jump_target, out_pc_plus4,
           out_reg_write, out_mem_read, out_mem_write, out_alu_src_imm,
           out_branch, out_jump, out_jump_reg, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt,
           out_write_reg, out_imm, out_jump_target, out_pc_plus4,
           out_reg_write, out_mem_read, out_mem_write, out_alu_src_imm,
           out_branch, out_jump, out_jump_reg, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_decode_stage_logic.sv
// ============================================================================
// Module  : alu_decode_logic
// Brief   : Combinational MIPS field split, immediate extension and control
//           decode for the supported instruction subset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode_logic
  import alu_decode_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic [DATA_W-1:0] inst,
  input  wire logic [DATA_W-1:0] pc,
  output ctrl_t                  ctrl,
  output logic [DATA_W-1:0]      imm,
  output logic [DATA_W-1:0]      jump_target,
  output logic [DATA_W-1:0]      pc_plus4
);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign pc_plus4    = pc + DATA_W'(4);
  assign jump_target = {pc_plus4[DATA_W-1:28], inst[25:0], 2'b00};
  assign imm_sext    = {{(DATA_W-16){inst[15]}}, inst[15:0]};
  assign imm_zext    = {{(DATA_W-16){1'b0}}, inst[15:0]};

  // Illegal encodings leave every enable at its cleared default.
  always_comb begin
    ctrl        = '0;
    imm         = '0;
    ctrl.opcode = inst[31:26];
    ctrl.funct  = inst[5:0];
    ctrl.rs     = inst[25:21];
    ctrl.rt     = inst[20:16];
    case (inst[31:26])
      RTYPE_OP: begin
        ctrl.write_reg = inst[15:11];
        case (inst[5:0])
          ADD_FUNCT, SUB_FUNCT, SLT_FUNCT: ctrl.reg_write = 1'b1;
          JR_FUNCT:                        ctrl.jump_reg  = 1'b1;
          default:                         ctrl.illegal   = 1'b1;
        endcase
      end
      ADDI_OP: begin
        ctrl.write_reg   = inst[20:16];
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        imm              = imm_sext;
      end
      XORI_OP: begin
        ctrl.write_reg   = inst[20:16];
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        imm              = imm_zext;
      end
      LW_OP: begin
        ctrl.write_reg   = inst[20:16];
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        imm              = imm_sext;
      end
      SW_OP: begin
        ctrl.write_reg   = inst[20:16];
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        imm              = imm_sext;
      end
      BEQ_OP, BNE_OP: begin
        ctrl.write_reg = inst[20:16];
        ctrl.branch    = 1'b1;
        imm            = imm_sext;
      end
      J_OP: ctrl.jump = 1'b1;
      JAL_OP: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.write_reg = LINK_REG;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_decode_stage.sv
// ============================================================================
// Module  : alu_decode_stage
// Brief   : Decode stage with a 2-entry FIFO skid buffer toward execute.
//           Optional perf counters: define ALU_DECODE_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              flush,
`ifdef ALU_DECODE_PERF_CNT_EN
  output logic [CNT_W-1:0]       perf_accepted,
  output logic [CNT_W-1:0]       perf_illegal,
`endif
  alu_decode_stage_if.slave      bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] jump_target;
    logic [DATA_W-1:0] pc_plus4;
  } entry_t;

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t dec;
  logic   push;
  logic   pop;

  alu_decode_logic #(.DATA_W(DATA_W)) u_logic (
    .inst        (bus.in_inst),
    .pc          (bus.in_pc),
    .ctrl        (dec.ctrl),
    .imm         (dec.imm),
    .jump_target (dec.jump_target),
    .pc_plus4    (dec.pc_plus4)
  );

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Head always holds the oldest entry; tail is only occupied in FULL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          head  <= dec;
          state <= ONE;
        end
        ONE: begin
          if (push && pop) begin
            head <= dec;
          end else if (push) begin
            tail  <= dec;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: if (pop) begin
          head  <= tail;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.out_opcode      = head.ctrl.opcode;
  assign bus.out_funct       = head.ctrl.funct;
  assign bus.out_rs          = head.ctrl.rs;
  assign bus.out_rt          = head.ctrl.rt;
  assign bus.out_write_reg   = head.ctrl.write_reg;
  assign bus.out_imm         = head.imm;
  assign bus.out_jump_target = head.jump_target;
  assign bus.out_pc_plus4    = head.pc_plus4;
  assign bus.out_reg_write   = head.ctrl.reg_write;
  assign bus.out_mem_read    = head.ctrl.mem_read;
  assign bus.out_mem_write   = head.ctrl.mem_write;
  assign bus.out_alu_src_imm = head.ctrl.alu_src_imm;
  assign bus.out_branch      = head.ctrl.branch;
  assign bus.out_jump        = head.ctrl.jump;
  assign bus.out_jump_reg    = head.ctrl.jump_reg;
  assign bus.out_illegal     = head.ctrl.illegal;

`ifdef ALU_DECODE_PERF_CNT_EN
  // Counters track handshakes, so a flush does not rewind them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_accepted <= '0;
      perf_illegal  <= '0;
    end else begin
      if (push)
        perf_accepted <= perf_accepted + CNT_W'(1);
      if (pop && head.ctrl.illegal)
        perf_illegal <= perf_illegal + CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Instruction-decode stage that produces the opcode/funct/operand-select controls the ALU consumes.
- Accepts 32-bit MIPS instruction words from fetch over a valid/ready handshake and splits them into fields and control bits.
- Forwards the result to execute through a 2-entry skid buffer.
- Covers the instruction subset the CPU implements: R-type ADD/SUB/SLT/JR, ADDI, XORI, LW, SW, BEQ, BNE, J, JAL.

Parameters:
- DATA_W, 32, instruction, PC and immediate width.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards buffered and incoming instructions.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept an instruction.
- in_inst  input  DATA_W  instruction word.
- in_pc  input  DATA_W  PC of in_inst.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  execute accepts the entry.
- out_opcode  output  6  inst[31:26].
- out_funct  output  6  inst[5:0].
- out_rs  output  5  inst[25:21].
- out_rt  output  5  inst[20:16].
- out_write_reg  output  5  write destination: rd for R-type, rt for I-type, 31 for JAL, 0 otherwise.
- out_imm  output  DATA_W  extended immediate.
- out_jump_target  output  DATA_W  {pc_plus4[31:28], inst[25:0], 2'b00}.
- out_pc_plus4  output  DATA_W  in_pc + 4, mod 2^32.
- out_reg_write, out_mem_read, out_mem_write, out_alu_src_imm, out_branch, out_jump, out_jump_reg  output  1 each  control bits.
- out_illegal  output  1  unsupported opcode/funct.

Behaviour:
- Transfers:
  - Input transfer occurs on a cycle with in_valid & in_ready.
  - Output transfer occurs on a cycle with out_valid & out_ready.
- Buffer state machine:
  - States: EMPTY, ONE, FULL. Transitions follow net push/pop each cycle.
  - in_ready = (state != FULL). It is derived from registered state only, never from out_ready.
  - Latency: an instruction accepted at edge N is on out_* after edge N, i.e. visible in cycle N+1, when the buffer was EMPTY or popped that same cycle.
  - Order is strictly FIFO.
  - Push and pop in the same cycle are both allowed in any state. In FULL, the pop frees the slot but in_ready was 0, so no push occurs.
  - Outputs come from the head register and are held stable while out_valid & !out_ready.
- Immediate extension:
  - Sign-extend inst[15:0] for ADDI, LW, SW, BEQ, BNE.
  - Zero-extend inst[15:0] for XORI.
  - out_imm = 0 for R-type, J and JAL.
- Control bits by instruction:
  - ADDI, XORI: reg_write = 1, alu_src_imm = 1.
  - LW: reg_write = 1, mem_read = 1, alu_src_imm = 1.
  - SW: mem_write = 1, alu_src_imm = 1.
  - BEQ, BNE: branch = 1.
  - J: jump = 1.
  - JAL: jump = 1, reg_write = 1, write_reg = 31.
  - R-type ADD/SUB/SLT: reg_write = 1.
  - R-type JR: jump_reg = 1, reg_write = 0.
- Illegal instructions:
  - Any other opcode, or RTYPE with any other funct, sets illegal = 1.
  - The instruction still flows through the buffer, with reg_write/mem_read/mem_write/branch/jump/jump_reg forced to 0.
- Flush:
  - State goes to EMPTY at the next edge; the incoming instruction that cycle is dropped.
  - Flush has priority over push and pop.
  - in_ready is unaffected by flush in the flush cycle.
- Reset (asynchronous, any time, including mid-transfer):
  - State = EMPTY, out_valid = 0, all out_* = 0.
  - in_ready = 1 once reset_n is deasserted.

Optional Feature:
- Macro: ALU_DECODE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_accepted and perf_illegal, CNT_W each.
  - perf_accepted counts input transfers; perf_illegal counts output transfers with out_illegal = 1.
  - Both wrap modulo 2^CNT_W, reset to 0, and are unaffected by flush.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared header: opcode and funct constants (RTYPE_OP = 6'h00, J_OP = 6'h02, JAL_OP = 6'h03, BEQ_OP = 6'h04, BNE_OP = 6'h05, ADDI_OP = 6'h08, XORI_OP = 6'h0E, LW_OP = 6'h23, SW_OP = 6'h2B; JR_FUNCT = 6'h08, ADD_FUNCT = 6'h20, SUB_FUNCT = 6'h22, SLT_FUNCT = 6'h2A), shared with the ALU and CPU.
- Sub-module: purely combinational alu_decode_logic (instruction + PC -> decoded bundle). The top level holds the skid buffer state machine and the counters.

Test Plan:
- ADDI sign extension: in_inst = 0x2128FFFC, pc = 0x00400000, out_ready = 1 -> next cycle out_valid = 1, rs = 9, rt = 8, write_reg = 8, imm = 0xFFFFFFFC, reg_write = 1, alu_src_imm = 1, pc_plus4 = 0x00400004.
- XORI and R-type:
  - 0x38628001 -> imm = 0x00008001, write_reg = 2.
  - 0x00221820 -> funct = 0x20, write_reg = 3, reg_write = 1, alu_src_imm = 0.
- JAL target: JAL 0x0C100010 at pc 0x00400000 -> jump = 1, write_reg = 31, jump_target = 0x00400040.
- Back-pressure: out_ready = 0, push ADD, SUB, SLT back-to-back -> in_ready = 0 after two accepts. SLT is held by fetch. Raise out_ready -> ADD, SUB, SLT emerge in order with no loss or duplication.
- Flush and illegal:
  - flush with the buffer FULL and in_valid = 1 -> out_valid = 0 next cycle, the incoming instruction is never output.
  - Opcode 0x3F, or RTYPE with funct 0x01 -> illegal = 1, all enables 0.
- Reset and counters: assert reset_n low mid-stall -> out_valid = 0 immediately. With ALU_DECODE_PERF_CNT_EN defined, 5 accepts including 1 illegal -> perf_accepted = 5, perf_illegal = 1.
